// File: rtl/reg_file_mp.sv
// Multi-port register file with registered reads, optional write-to-read bypass,
// per-port read hold, a hardwired zero register and a combinational debug tap.
`timescale 1ns / 1ps

module reg_file_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]        dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_data
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("reg_file_mp: NUM_RD must be 1..4");
  end
  if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
    $error("reg_file_mp: NUM_WR must be 1..2");
  end
  if (ZERO_REG > 1 || BYPASS > 1) begin : g_bad_flags
    $error("reg_file_mp: ZERO_REG and BYPASS must be 0 or 1");
  end
  if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 || ADDR_WIDTH > 16) begin : g_bad_widths
    $error("reg_file_mp: DATA_WIDTH must be >= 1 and ADDR_WIDTH 1..16");
  end

  logic [ADDR_WIDTH-1:0] raddr_a [NUM_RD];
  logic [ADDR_WIDTH-1:0] waddr_a [NUM_WR];
  word_t                 wdata_a [NUM_WR];
  logic [NUM_WR-1:0]     wr_ok;

  word_t mem_q   [Depth];
  word_t mem_d   [Depth];
  word_t rdata_q [NUM_RD];
  word_t rdata_d [NUM_RD];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign raddr_a[i]                       = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdata_q[i];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign waddr_a[j] = waddr[j*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[j] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
    assign wr_ok[j]   = we[j] && !((ZERO_REG != 0) && (waddr_a[j] == '0));
  end

  // Later ports overwrite earlier ones, so port 1 wins an address collision.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_ok[j]) begin
        mem_d[waddr_a[j]] = wdata_a[j];
      end
    end
  end

  // Reading mem_d forwards same-edge write data with the same priority as the store.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rdata_d[i] = rdata_q[i];
      if (rd_en[i]) begin
        if ((ZERO_REG != 0) && (raddr_a[i] == '0)) begin
          rdata_d[i] = '0;
        end else if (BYPASS != 0) begin
          rdata_d[i] = mem_d[raddr_a[i]];
        end else begin
          rdata_d[i] = mem_q[raddr_a[i]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < Depth; k++) begin
        mem_q[k] <= '0;
      end
      for (int i = 0; i < NUM_RD; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : mem_q[dbg_addr];

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised scoreboard bench for reg_file_mp (2 read ports, 2 write ports, zero reg, bypass).
`timescale 1ns / 1ps

module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] model  [32];
  logic [31:0] rd_exp [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  always #5 clk = ~clk;

  reg_file_mp #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_RD    (2),
    .NUM_WR    (2),
    .ZERO_REG  (1),
    .BYPASS    (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en),
    .raddr   (raddr),
    .rdata   (rdata),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model applies the write rules and queues the read result.
  task automatic cycle(input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [1:0] wen, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1);
    logic [31:0] nm [32];
    logic [4:0]  da;
    @(negedge clk);
    da       = 5'($urandom_range(0, 31));
    rd_en    = ren;
    raddr    = {ra1, ra0};
    we       = wen;
    waddr    = {wa1, wa0};
    wdata    = {wd1, wd0};
    dbg_addr = da;
    #1;
    chk("dbg_data", dbg_data, model[da]);
    nm = model;
    if (wen[0] && wa0 != 5'd0) nm[wa0] = wd0;
    if (wen[1] && wa1 != 5'd0) nm[wa1] = wd1;
    if (ren[0]) rd_exp[0] = nm[ra0];
    if (ren[1]) rd_exp[1] = nm[ra1];
    q0.push_back(rd_exp[0]);
    q1.push_back(rd_exp[1]);
    model = nm;
  endtask

  task automatic idle();
    rd_en = 2'b00;
    we    = 2'b00;
  endtask

  // Reset lands just before an edge that carries a write; that write must be lost.
  task automatic mid_reset();
    @(negedge clk);
    rd_en = 2'b11;
    we    = 2'b11;
    waddr = {5'd12, 5'd13};
    wdata = {32'hCAFE_0001, 32'hCAFE_0002};
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_rdata0", rdata[31:0], 32'h0);
    chk("reset_rdata1", rdata[63:32], 32'h0);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      chk("reset_dbg", dbg_data, 32'h0);
    end
    idle();
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    rd_exp[0] = 32'h0;
    rd_exp[1] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) chk("rdata0", rdata[31:0], q0.pop_front());
      if (q1.size() > 0) chk("rdata1", rdata[63:32], q1.pop_front());
    end
  end

  initial begin : stimulus
    logic [4:0] a0, a1, w0, w1;
    rst_n    = 1'b0;
    rd_en    = 2'b00;
    raddr    = '0;
    we       = 2'b00;
    waddr    = '0;
    wdata    = '0;
    dbg_addr = 5'd0;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    rd_exp[0] = 32'h0;
    rd_exp[1] = 32'h0;
    #1;
    chk("init_rdata0", rdata[31:0], 32'h0);
    chk("init_rdata1", rdata[63:32], 32'h0);
    chk("init_dbg", dbg_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write then read r7.
    cycle(2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 32'hDEAD_BEEF, 32'h0);
    cycle(2'b01, 5'd7, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    // Bypass on r9.
    cycle(2'b00, 5'd0, 5'd0, 2'b01, 5'd9, 5'd0, 32'h11, 32'h0);
    cycle(2'b10, 5'd0, 5'd9, 2'b01, 5'd9, 5'd0, 32'h22, 32'h0);
    // Zero register with a bypass read of r0.
    cycle(2'b11, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // Hold: r3=5 read, then rd_en0 low while r3 changes.
    cycle(2'b00, 5'd0, 5'd0, 2'b01, 5'd3, 5'd0, 32'h5, 32'h0);
    cycle(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    cycle(2'b00, 5'd3, 5'd0, 2'b01, 5'd3, 5'd0, 32'h6, 32'h0);
    cycle(2'b00, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    cycle(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    // Dual write collision on r4 with forwarded read on both ports.
    cycle(2'b11, 5'd4, 5'd4, 2'b11, 5'd4, 5'd4, 32'hA, 32'hB);
    cycle(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    mid_reset();
    cycle(2'b11, 5'd12, 5'd13, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        a0 = 5'($urandom_range(0, 3)); a1 = 5'($urandom_range(0, 3));
        w0 = 5'($urandom_range(0, 3)); w1 = 5'($urandom_range(0, 3));
      end else begin
        a0 = 5'($urandom); a1 = 5'($urandom);
        w0 = 5'($urandom); w1 = 5'($urandom);
      end
      cycle(2'($urandom), a0, a1, 2'($urandom), w0, w1, $urandom, $urandom);
      if (n == 700) begin
        mid_reset();
      end
    end

    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
